// File: rtl/serial_link_credit_return.sv
// Receive-side credit bookkeeping for the serial link.
// Counts popped RX FIFO entries and returns them to the peer. Credits ride on
// the next outgoing data packet, or go out in a forced credit-only packet when
// too many are pending or they have been held too long.
module serial_link_credit_return #(
  parameter int unsigned NumCredits    = 8,
  parameter int unsigned ForceThresh   = 6,
  parameter int unsigned MaxWaitCycles = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          consume_i,
  input  logic                          tx_hs_i,
  output logic [$clog2(NumCredits):0]   credits_o,
  output logic                          force_req_o,
  input  logic                          force_ack_i,
  output logic [$clog2(NumCredits):0]   pending_o,
  output logic                          overflow_o
);

  localparam int unsigned CW = $clog2(NumCredits) + 1;
  localparam int unsigned WW = $clog2(MaxWaitCycles + 1);

  localparam logic [CW-1:0] Full     = CW'(NumCredits);
  localparam logic [CW-1:0] Thresh   = CW'(ForceThresh);
  localparam logic [WW-1:0] WaitMax  = WW'(MaxWaitCycles);
  localparam logic [WW-1:0] WaitLast = WW'(MaxWaitCycles - 1);

  typedef enum logic [0:0] {StIdle, StForceReq} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          overflow_q, overflow_d;
  logic          take;
  logic          timeout;

  // Credits are always returned straight from the pending register.
  assign credits_o   = pending_q;
  assign pending_o   = pending_q;
  assign force_req_o = (state_q == StForceReq);
  assign overflow_o  = overflow_q;

  // An ack only counts while a credit-only packet is actually requested.
  assign take    = tx_hs_i | (force_req_o & force_ack_i);
  assign timeout = !take && (pending_q != '0) && (wait_q >= WaitLast);

  // Next-state for pending credits, wait counter, overflow flag and FSM.
  always_comb begin
    pending_d  = pending_q;
    wait_d     = wait_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (flush_i) begin
      pending_d  = '0;
      wait_d     = '0;
      overflow_d = 1'b0;
      state_d    = StIdle;
    end else begin
      // A consume coinciding with a take belongs to the next return.
      if (take) begin
        pending_d = {{(CW-1){1'b0}}, consume_i};
      end else if (consume_i) begin
        if (pending_q == Full) begin
          overflow_d = 1'b1;
        end else begin
          pending_d = pending_q + 1'b1;
        end
      end

      if (take || (pending_q == '0)) begin
        wait_d = '0;
      end else if ((state_q == StIdle) && (wait_q != WaitMax)) begin
        wait_d = wait_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if ((pending_d >= Thresh) || timeout) begin
            state_d = StForceReq;
          end
        end
        StForceReq: begin
          if (take) begin
            state_d = (pending_d >= Thresh) ? StForceReq : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_serial_link_credit_return.sv
// Directed bench for serial_link_credit_return with default parameters.
module tb_serial_link_credit_return;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       consume_i = 1'b0;
  logic       tx_hs_i = 1'b0;
  logic       force_ack_i = 1'b0;
  logic [3:0] credits_o;
  logic       force_req_o;
  logic [3:0] pending_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  serial_link_credit_return #(
    .NumCredits   (8),
    .ForceThresh  (6),
    .MaxWaitCycles(64)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .consume_i  (consume_i),
    .tx_hs_i    (tx_hs_i),
    .credits_o  (credits_o),
    .force_req_o(force_req_o),
    .force_ack_i(force_ack_i),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    // Reset
    #2;
    check("rst_pending", pending_o, 0);
    check("rst_credits", credits_o, 0);
    check("rst_force", force_req_o, 0);
    check("rst_overflow", overflow_o, 0);
    step(1);
    rst_ni = 1'b1;
    step(1);

    // 3 consumes, piggyback return
    consume_i = 1'b1;
    step(3);
    consume_i = 1'b0;
    check("t1_pending3", pending_o, 3);
    check("t1_noforce_a", force_req_o, 0);
    tx_hs_i = 1'b1;
    check("t1_credits3", credits_o, 3);
    step(1);
    tx_hs_i = 1'b0;
    check("t1_pending0", pending_o, 0);
    check("t1_noforce_b", force_req_o, 0);

    // 6 consumes force a credit-only packet
    consume_i = 1'b1;
    step(5);
    check("t2_noforce5", force_req_o, 0);
    step(1);
    consume_i = 1'b0;
    check("t2_force6", force_req_o, 1);
    check("t2_pending6", pending_o, 6);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t2_force_hold", force_req_o, 1);
    end
    force_ack_i = 1'b1;
    check("t2_credits6", credits_o, 6);
    step(1);
    force_ack_i = 1'b0;
    check("t2_force_drop", force_req_o, 0);
    check("t2_pending0", pending_o, 0);

    // Single consume, timeout after 64 cycles
    consume_i = 1'b1;
    step(1);
    consume_i = 1'b0;
    check("t3_pending1", pending_o, 1);
    step(63);
    check("t3_noforce63", force_req_o, 0);
    step(1);
    check("t3_force64", force_req_o, 1);
    force_ack_i = 1'b1;
    check("t3_credits1", credits_o, 1);
    step(1);
    force_ack_i = 1'b0;
    check("t3_force_drop", force_req_o, 0);
    check("t3_pending0", pending_o, 0);

    // Consume and tx in the same cycle
    consume_i = 1'b1;
    step(4);
    tx_hs_i = 1'b1;
    check("t4_credits4", credits_o, 4);
    step(1);
    consume_i = 1'b0;
    tx_hs_i = 1'b0;
    check("t4_pending1", pending_o, 1);
    // Stray ack without a request is ignored
    force_ack_i = 1'b1;
    step(1);
    force_ack_i = 1'b0;
    check("t4_stray_ack", pending_o, 1);
    tx_hs_i = 1'b1;
    step(1);
    tx_hs_i = 1'b0;
    check("t4_cleared", pending_o, 0);
    // tx with nothing pending
    tx_hs_i = 1'b1;
    check("t4_credits0", credits_o, 0);
    step(1);
    tx_hs_i = 1'b0;
    check("t4_still0", pending_o, 0);

    // Saturation and overflow, then flush
    consume_i = 1'b1;
    step(8);
    check("t5_pending8", pending_o, 8);
    check("t5_no_ovf", overflow_o, 0);
    step(1);
    consume_i = 1'b0;
    check("t5_sat8", pending_o, 8);
    check("t5_ovf", overflow_o, 1);
    step(3);
    check("t5_ovf_sticky", overflow_o, 1);
    flush_i = 1'b1;
    consume_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    consume_i = 1'b0;
    check("t5_flush_pending", pending_o, 0);
    check("t5_flush_ovf", overflow_o, 0);
    check("t5_flush_force", force_req_o, 0);

    // Simultaneous tx and ack count as one take
    consume_i = 1'b1;
    step(6);
    consume_i = 1'b0;
    check("t6_force", force_req_o, 1);
    tx_hs_i = 1'b1;
    force_ack_i = 1'b1;
    step(1);
    tx_hs_i = 1'b0;
    force_ack_i = 1'b0;
    check("t6_pending0", pending_o, 0);
    check("t6_force_drop", force_req_o, 0);

    // Async reset mid-ForceReq
    consume_i = 1'b1;
    step(7);
    consume_i = 1'b0;
    check("t7_pending7", pending_o, 7);
    check("t7_force", force_req_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t7_rst_pending", pending_o, 0);
    check("t7_rst_credits", credits_o, 0);
    check("t7_rst_force", force_req_o, 0);
    check("t7_rst_ovf", overflow_o, 0);
    step(1);
    rst_ni = 1'b1;
    step(1);
    check("t7_after_rst", pending_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
